oflow_mem_history_reader: RTL and testbench
===========================================

OFLOW_MEM_HISTORY_READER -- requirements
Module: oflow_mem_history_reader

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- DATA_WIDTH, 290, width of one buffer entry.
- OFFSET_WIDTH, 6, object offset width.
- TOTAL_FRAME_NUM_WIDTH, 8, frame serial number width (0-255).
- NUM_OF_HISTORY_FRAMES_WIDTH, 3, history depth width.

REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, single clock; all state changes on posedge.
- reset, in, 1, asynchronous, active-high.
- start, in, 1, launch one history sweep.
- frame_num, in, TOTAL_FRAME_NUM_WIDTH, current frame.
- num_of_history_frames, in, NUM_OF_HISTORY_FRAMES_WIDTH, history depth H.
- num_of_objects, in, OFFSET_WIDTH+1, objects per history frame N.
- rd_en, out, 1, buffer read strobe.
- rd_frame_num, out, TOTAL_FRAME_NUM_WIDTH, buffer read frame.
- rd_offset_0, out, OFFSET_WIDTH, buffer read offset, port 0.
- rd_offset_1, out, OFFSET_WIDTH, buffer read offset, port 1.
- data_out_0, in, DATA_WIDTH, buffer read data, port 0.
- data_out_1, in, DATA_WIDTH, buffer read data, port 1.
- hist_valid, out, 1, output pair valid.
- hist_ready, in, 1, downstream accepts the pair.
- hist_data_0, out, DATA_WIDTH, returned entry, port 0.
- hist_data_1, out, DATA_WIDTH, returned entry, port 1.
- hist_vld_1, out, 1, hist_data_1 carries a real object.
- hist_frame_num, out, TOTAL_FRAME_NUM_WIDTH, source frame of the pair.
- hist_last, out, 1, last pair of the sweep.
- busy, out, 1, sweep in progress.
- done, out, 1, one-cycle completion pulse.

Function
REQ-003 The buffer has a fixed 1-cycle read latency: data_out_0/1 sampled at edge t+1 belong to the rd_en issued at edge t.
REQ-004 FSM states: IDLE, FETCH, DRAIN, DONE. Encoding is free.
REQ-005 IDLE with start=1 SHALL latch frame_num as F, H and N, then go to FETCH. start in any other state SHALL be ignored.
REQ-006 If the latched H=0 or N=0, the block SHALL go IDLE->DONE with no rd_en asserted.
REQ-007 Read order:
- Frames F-1, F-2, ..., F-H, computed modulo 2^TOTAL_FRAME_NUM_WIDTH (F=1, H=3 reads frames 0, 255, 254).
- Within each frame, offset pairs (0,1), (2,3), ... up to N-1.
REQ-008 For odd N, the final pair of each frame SHALL use rd_offset_1 = rd_offset_0 and drive hist_vld_1=0. Otherwise hist_vld_1=1.
REQ-009 Output staging is a 2-entry FIFO. Each entry holds data_0, data_1, vld_1, frame and last.
REQ-010 Credit rule: rd_en SHALL be asserted only when (FIFO occupancy + reads in flight) < 2. Overflow SHALL be impossible.
REQ-011 hist_valid = FIFO not empty. The head is popped on hist_valid & hist_ready. Push and pop in the same cycle SHALL both take effect.
REQ-012 While hist_valid=1 and hist_ready=0, all hist_* outputs SHALL hold stable.
REQ-013 With hist_ready held at 1, throughput SHALL be one pair per cycle. The first hist_valid occurs 2 cycles after the start edge.
REQ-014 hist_last=1 only on the pair for frame F-H at the highest offset.
REQ-015 FETCH->DRAIN after the last rd_en is issued. DRAIN->DONE when the hist_last pair is accepted. DONE->IDLE unconditionally after one cycle.
REQ-016 done=1 exactly during DONE. busy=1 in FETCH, DRAIN and DONE, and 0 in IDLE.
REQ-017 rd_frame_num, rd_offset_0 and rd_offset_1 SHALL be 0 whenever rd_en=0.

Reset
REQ-018 reset=1 SHALL asynchronously force:
- FSM to IDLE;
- FIFO empty and in-flight count 0;
- all outputs 0: rd_en, rd_*, hist_valid, hist_data_0, hist_data_1, hist_vld_1, hist_frame_num, hist_last, busy, done.
REQ-019 Reset asserted mid-sweep SHALL discard all pending data. Returned buffer data arriving after reset SHALL be dropped.
REQ-020 After reset deassertion, the first accepted start SHALL begin a clean sweep.

Verification
REQ-021 Scenario 1: F=6, H=1, N=2, hist_ready=1, buffer preloaded at frame 5 offsets 0/1 -> exactly one rd_en (frame 5, offsets 0,1); one pair out with hist_vld_1=1 and hist_last=1; done 1 cycle later.
REQ-022 Scenario 2: F=1, H=3, N=4 -> rd_frame_num sequence 0,0,255,255,254,254; offsets (0,1),(2,3) repeated; 6 pairs out; hist_last only on the sixth.
REQ-023 Scenario 3: F=10, H=2, N=3 -> 4 pairs out; the pairs at offset 2 have hist_vld_1=0.
REQ-024 Scenario 4: H=5, N=8, hist_ready toggled randomly and held 0 for 10 cycles -> no FIFO overflow; outputs stable while stalled; 20 pairs delivered in order.
REQ-025 Scenario 5: H=0 -> no rd_en; done pulses 1 cycle after start. A second start asserted during busy produces no effect.
REQ-026 Scenario 6: reset asserted at the 3rd pair of an H=4, N=6 sweep -> all outputs 0 in the same cycle; a new sweep after release completes normally.

Source files
------------

// File: rtl/oflow_mem_history_reader.sv
// History sweep reader: walks frames F-1..F-H, issues paired buffer reads and
// returns each pair through a 2-entry credit-limited output FIFO.
module oflow_mem_history_reader #(
    parameter int unsigned DATA_WIDTH                  = 290,
    parameter int unsigned OFFSET_WIDTH                = 6,
    parameter int unsigned TOTAL_FRAME_NUM_WIDTH       = 8,
    parameter int unsigned NUM_OF_HISTORY_FRAMES_WIDTH = 3
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   start,
    input  logic [TOTAL_FRAME_NUM_WIDTH-1:0]       frame_num,
    input  logic [NUM_OF_HISTORY_FRAMES_WIDTH-1:0] num_of_history_frames,
    input  logic [OFFSET_WIDTH:0]                  num_of_objects,
    output logic                                   rd_en,
    output logic [TOTAL_FRAME_NUM_WIDTH-1:0]       rd_frame_num,
    output logic [OFFSET_WIDTH-1:0]                rd_offset_0,
    output logic [OFFSET_WIDTH-1:0]                rd_offset_1,
    input  logic [DATA_WIDTH-1:0]                  data_out_0,
    input  logic [DATA_WIDTH-1:0]                  data_out_1,
    output logic                                   hist_valid,
    input  logic                                   hist_ready,
    output logic [DATA_WIDTH-1:0]                  hist_data_0,
    output logic [DATA_WIDTH-1:0]                  hist_data_1,
    output logic                                   hist_vld_1,
    output logic [TOTAL_FRAME_NUM_WIDTH-1:0]       hist_frame_num,
    output logic                                   hist_last,
    output logic                                   busy,
    output logic                                   done
);

    localparam int unsigned CW = OFFSET_WIDTH + 2;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t                                 state;
    logic [TOTAL_FRAME_NUM_WIDTH-1:0]       cur_frame;
    logic [NUM_OF_HISTORY_FRAMES_WIDTH-1:0] hist_num;
    logic [NUM_OF_HISTORY_FRAMES_WIDTH-1:0] frame_idx;
    logic [OFFSET_WIDTH:0]                  obj_num;
    logic [OFFSET_WIDTH:0]                  cur_off;
    logic                                   fl_vld_1;
    logic                                   fl_last;
    logic [1:0]                             occ;
    logic [DATA_WIDTH-1:0]                  e1_data_0;
    logic [DATA_WIDTH-1:0]                  e1_data_1;
    logic                                   e1_vld_1;
    logic [TOTAL_FRAME_NUM_WIDTH-1:0]       e1_frame;
    logic                                   e1_last;

    logic       pop;
    logic       push;
    logic [1:0] occ_after_pop;
    logic [1:0] occ_next;
    logic       pair_end;
    logic       odd_tail;
    logic       last_frame;
    logic       issue;

    assign hist_valid = (occ != 2'd0);

    // The read in flight is exactly the rd_en cycle, so its data is pushed
    // on the following edge; issue only if that leaves room for it.
    always_comb begin
        pop           = hist_valid & hist_ready;
        push          = rd_en;
        occ_after_pop = occ - {1'b0, pop};
        occ_next      = occ_after_pop + {1'b0, push};
        pair_end      = (CW'(cur_off) + CW'(2)) >= CW'(obj_num);
        odd_tail      = (CW'(cur_off) + CW'(1)) >= CW'(obj_num);
        last_frame    = (frame_idx == (hist_num - NUM_OF_HISTORY_FRAMES_WIDTH'(1)));
        issue         = (state == FETCH) && (occ_next < 2'd2);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            cur_frame      <= '0;
            hist_num       <= '0;
            frame_idx      <= '0;
            obj_num        <= '0;
            cur_off        <= '0;
            fl_vld_1       <= 1'b0;
            fl_last        <= 1'b0;
            occ            <= '0;
            e1_data_0      <= '0;
            e1_data_1      <= '0;
            e1_vld_1       <= 1'b0;
            e1_frame       <= '0;
            e1_last        <= 1'b0;
            rd_en          <= 1'b0;
            rd_frame_num   <= '0;
            rd_offset_0    <= '0;
            rd_offset_1    <= '0;
            hist_data_0    <= '0;
            hist_data_1    <= '0;
            hist_vld_1     <= 1'b0;
            hist_frame_num <= '0;
            hist_last      <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            rd_en        <= 1'b0;
            rd_frame_num <= '0;
            rd_offset_0  <= '0;
            rd_offset_1  <= '0;
            done         <= 1'b0;
            occ          <= occ_next;

            // Shift-register FIFO: head lives in the hist_* registers; a push
            // landing in slot 0 overrides the shift from slot 1.
            if (pop) begin
                hist_data_0    <= e1_data_0;
                hist_data_1    <= e1_data_1;
                hist_vld_1     <= e1_vld_1;
                hist_frame_num <= e1_frame;
                hist_last      <= e1_last;
            end
            if (push) begin
                if (occ_after_pop == 2'd0) begin
                    hist_data_0    <= data_out_0;
                    hist_data_1    <= data_out_1;
                    hist_vld_1     <= fl_vld_1;
                    hist_frame_num <= rd_frame_num;
                    hist_last      <= fl_last;
                end else begin
                    e1_data_0 <= data_out_0;
                    e1_data_1 <= data_out_1;
                    e1_vld_1  <= fl_vld_1;
                    e1_frame  <= rd_frame_num;
                    e1_last   <= fl_last;
                end
            end

            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (start) begin
                        cur_frame <= frame_num - TOTAL_FRAME_NUM_WIDTH'(1);
                        hist_num  <= num_of_history_frames;
                        obj_num   <= num_of_objects;
                        frame_idx <= '0;
                        cur_off   <= '0;
                        busy      <= 1'b1;
                        if ((num_of_history_frames == '0) || (num_of_objects == '0)) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    if (issue) begin
                        rd_en        <= 1'b1;
                        rd_frame_num <= cur_frame;
                        rd_offset_0  <= cur_off[OFFSET_WIDTH-1:0];
                        rd_offset_1  <= odd_tail ? cur_off[OFFSET_WIDTH-1:0]
                                                 : cur_off[OFFSET_WIDTH-1:0] + OFFSET_WIDTH'(1);
                        fl_vld_1     <= !odd_tail;
                        fl_last      <= pair_end && last_frame;
                        if (pair_end) begin
                            cur_off   <= '0;
                            cur_frame <= cur_frame - TOTAL_FRAME_NUM_WIDTH'(1);
                            frame_idx <= frame_idx + NUM_OF_HISTORY_FRAMES_WIDTH'(1);
                            if (last_frame) begin
                                state <= DRAIN;
                            end
                        end else begin
                            cur_off <= cur_off + (OFFSET_WIDTH + 1)'(2);
                        end
                    end
                end
                DRAIN: begin
                    if (pop && hist_last) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_oflow_mem_history_reader.sv
// Bench for oflow_mem_history_reader: table of sweeps plus random sweeps, each
// checked against a pair list built directly from frame/offset arithmetic.
module tb_oflow_mem_history_reader;

    localparam int DW = 290;
    localparam int OW = 6;
    localparam int TW = 8;
    localparam int HW = 3;
    localparam int BUDGET = 2000;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [TW-1:0] frame_num = '0;
    logic [HW-1:0] num_of_history_frames = '0;
    logic [OW:0]   num_of_objects = '0;
    logic          rd_en;
    logic [TW-1:0] rd_frame_num;
    logic [OW-1:0] rd_offset_0;
    logic [OW-1:0] rd_offset_1;
    logic [DW-1:0] data_out_0;
    logic [DW-1:0] data_out_1;
    logic          hist_valid;
    logic          hist_ready = 1'b0;
    logic [DW-1:0] hist_data_0;
    logic [DW-1:0] hist_data_1;
    logic          hist_vld_1;
    logic [TW-1:0] hist_frame_num;
    logic          hist_last;
    logic          busy;
    logic          done;

    oflow_mem_history_reader #(
        .DATA_WIDTH(DW),
        .OFFSET_WIDTH(OW),
        .TOTAL_FRAME_NUM_WIDTH(TW),
        .NUM_OF_HISTORY_FRAMES_WIDTH(HW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .frame_num(frame_num),
        .num_of_history_frames(num_of_history_frames),
        .num_of_objects(num_of_objects),
        .rd_en(rd_en),
        .rd_frame_num(rd_frame_num),
        .rd_offset_0(rd_offset_0),
        .rd_offset_1(rd_offset_1),
        .data_out_0(data_out_0),
        .data_out_1(data_out_1),
        .hist_valid(hist_valid),
        .hist_ready(hist_ready),
        .hist_data_0(hist_data_0),
        .hist_data_1(hist_data_1),
        .hist_vld_1(hist_vld_1),
        .hist_frame_num(hist_frame_num),
        .hist_last(hist_last),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    // Buffer contents are a fixed function of (frame, offset).
    function automatic logic [DW-1:0] word(input logic [TW-1:0] f, input logic [OW-1:0] o);
        return DW'({19{f, ~o, 2'b01}}) ^ (DW'(o) << 250);
    endfunction

    // Read data is presented during the rd_en cycle and sampled on the next edge.
    always_comb begin
        data_out_0 = rd_en ? word(rd_frame_num, rd_offset_0) : '1;
        data_out_1 = rd_en ? word(rd_frame_num, rd_offset_1) : '1;
    end

    typedef struct {
        logic [TW-1:0] frame;
        logic [OW-1:0] o0;
        logic [OW-1:0] o1;
        logic          vld1;
        logic          last;
    } pair_t;

    typedef struct {
        int f;
        int h;
        int n;
        int mode;      // 0: ready=1, 1: random ready, 2: random with a 10-cycle stall
        bit poke;      // extra start pulse while busy
        int rst_pair;  // >0: assert reset when this pair is presented
        int exp_pairs;
    } vec_t;

    int    n_checks = 0;
    int    n_fail = 0;
    pair_t exp_q[$];
    vec_t  vecs[10];

    task automatic check(input string name, input logic [1023:0] act, input logic [1023:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic logic [1023:0] out_pack();
        return 1024'({hist_valid, hist_data_0, hist_data_1, hist_vld_1, hist_frame_num, hist_last});
    endfunction

    function automatic logic [1023:0] all_outputs();
        return 1024'({rd_en, rd_frame_num, rd_offset_0, rd_offset_1, hist_valid, hist_data_0,
                      hist_data_1, hist_vld_1, hist_frame_num, hist_last, busy, done});
    endfunction

    task automatic build_model(input int f, input int h, input int n);
        pair_t p;
        exp_q.delete();
        for (int hh = 1; hh <= h; hh++) begin
            for (int o = 0; o < n; o += 2) begin
                p.frame = TW'(f - hh);
                p.o0    = OW'(o);
                p.o1    = (o + 1 < n) ? OW'(o + 1) : OW'(o);
                p.vld1  = (o + 1 < n);
                p.last  = (hh == h) && (o + 2 >= n);
                exp_q.push_back(p);
            end
        end
    endtask

    task automatic run_sweep(input vec_t v);
        int             cyc;
        int             rd_idx;
        int             out_idx;
        int             first_valid;
        int             done_cyc;
        bit             aborted;
        bit             prev_stall;
        bit             r;
        logic [1023:0]  prev_snap;
        logic [1023:0]  req;
        pair_t          p;

        build_model(v.f, v.h, v.n);
        @(negedge clk);
        frame_num             = TW'(v.f);
        num_of_history_frames = HW'(v.h);
        num_of_objects        = (OW + 1)'(v.n);
        start                 = 1'b1;
        hist_ready            = (v.mode == 0);
        @(posedge clk);
        #1;
        start                 = 1'b0;
        frame_num             = TW'($urandom);
        num_of_history_frames = HW'($urandom);
        num_of_objects        = (OW + 1)'($urandom);

        cyc = 0; rd_idx = 0; out_idx = 0; first_valid = -1; done_cyc = -1;
        aborted = 1'b0; prev_stall = 1'b0; prev_snap = '0;
        while (cyc < BUDGET && done_cyc < 0 && !aborted) begin
            @(negedge clk);
            if (v.rst_pair > 0 && hist_valid && out_idx == v.rst_pair - 1) begin
                reset = 1'b1;
                #1;
                check("reset_outputs_zero", all_outputs(), '0);
                @(negedge clk);
                check("reset_held_zero", all_outputs(), '0);
                reset = 1'b0;
                hist_ready = 1'b0;
                aborted = 1'b1;
            end else begin
                check("busy_during_sweep", 1024'(busy), 1024'(1));
                if (rd_en) begin
                    if (rd_idx < exp_q.size()) begin
                        p = exp_q[rd_idx];
                        check("rd_addr", 1024'({rd_frame_num, rd_offset_0, rd_offset_1}),
                              1024'({p.frame, p.o0, p.o1}));
                    end else begin
                        check("rd_extra", 1024'(rd_idx), 1024'(exp_q.size()));
                    end
                    rd_idx++;
                end else begin
                    check("rd_idle_zero", 1024'({rd_frame_num, rd_offset_0, rd_offset_1}), '0);
                end
                if (prev_stall) begin
                    check("stall_hold", out_pack(), prev_snap);
                end
                if (hist_valid) begin
                    if (first_valid < 0) first_valid = cyc;
                    if (out_idx < exp_q.size()) begin
                        p = exp_q[out_idx];
                        req = 1024'({1'b1, word(p.frame, p.o0), word(p.frame, p.o1),
                                     p.vld1, p.frame, p.last});
                        check("pair", out_pack(), req);
                    end else begin
                        check("pair_extra", 1024'(out_idx), 1024'(exp_q.size()));
                    end
                end
                if (done) done_cyc = cyc;

                case (v.mode)
                    0:       r = 1'b1;
                    1:       r = ($urandom_range(0, 3) != 0);
                    default: r = (cyc >= 4 && cyc < 14) ? 1'b0 : ($urandom_range(0, 1) == 1);
                endcase
                hist_ready = r;
                if (hist_valid && r) out_idx++;
                prev_stall = hist_valid && !r;
                prev_snap  = out_pack();

                if (v.poke && cyc == 1) begin
                    start                 = 1'b1;
                    frame_num             = TW'($urandom);
                    num_of_history_frames = 3'd7;
                    num_of_objects        = 7'd64;
                end else begin
                    start = 1'b0;
                end
                cyc++;
            end
        end
        start = 1'b0;

        if (!aborted) begin
            if (done_cyc < 0) check("done_timeout", 1024'(0), 1024'(1));
            check("pairs_out", 1024'(out_idx), 1024'(v.exp_pairs));
            check("reads_issued", 1024'(rd_idx), 1024'(v.exp_pairs));
            if (v.exp_pairs > 0) check("first_valid_cycle", 1024'(first_valid), 1024'(2));
            if (v.mode == 0)
                check("done_cycle", 1024'(done_cyc), 1024'((v.exp_pairs == 0) ? 0 : v.exp_pairs + 2));
            @(negedge clk);
            check("idle_after_done", 1024'({busy, done, hist_valid, rd_en}), '0);
        end
        hist_ready = 1'b0;
    endtask

    initial begin
        vec_t rv;

        vecs[0] = '{f: 6,   h: 1, n: 2,  mode: 0, poke: 0, rst_pair: 0, exp_pairs: 1};
        vecs[1] = '{f: 1,   h: 3, n: 4,  mode: 0, poke: 0, rst_pair: 0, exp_pairs: 6};
        vecs[2] = '{f: 10,  h: 2, n: 3,  mode: 0, poke: 0, rst_pair: 0, exp_pairs: 4};
        vecs[3] = '{f: 77,  h: 5, n: 8,  mode: 2, poke: 0, rst_pair: 0, exp_pairs: 20};
        vecs[4] = '{f: 33,  h: 0, n: 5,  mode: 0, poke: 0, rst_pair: 0, exp_pairs: 0};
        vecs[5] = '{f: 40,  h: 2, n: 0,  mode: 0, poke: 0, rst_pair: 0, exp_pairs: 0};
        vecs[6] = '{f: 200, h: 4, n: 6,  mode: 0, poke: 0, rst_pair: 3, exp_pairs: 12};
        vecs[7] = '{f: 201, h: 4, n: 6,  mode: 0, poke: 1, rst_pair: 0, exp_pairs: 12};
        vecs[8] = '{f: 0,   h: 7, n: 64, mode: 1, poke: 1, rst_pair: 0, exp_pairs: 224};
        vecs[9] = '{f: 128, h: 3, n: 1,  mode: 0, poke: 1, rst_pair: 0, exp_pairs: 3};

        #2;
        reset = 1'b1;
        #1;
        check("reset_state", all_outputs(), '0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_sweep(vecs[i]);
        end

        for (int i = 0; i < 8; i++) begin
            rv.f        = $urandom_range(0, 255);
            rv.h        = $urandom_range(0, 7);
            rv.n        = $urandom_range(0, 64);
            rv.mode     = (i % 3);
            rv.poke     = (i % 2 == 1);
            rv.rst_pair = 0;
            rv.exp_pairs = rv.h * ((rv.n + 1) / 2);
            run_sweep(rv);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
